// File: rtl/rw_pkg.sv
// Shared types and limits for the read/write/ready responder.
package rw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  localparam int unsigned MAX_WAIT = 7;
  localparam int unsigned CNT_W    = 3;

endpackage

// File: rtl/rw_regfile.sv
// Register file: synchronous write, synchronous clear-on-reset, combinational read.
module rw_regfile #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/rw_responder_properties.sv
// Protocol invariants for rw_responder, attached to every instance by bind.
module rw_responder_properties #(
  parameter int unsigned WAIT = 1
) (
  input logic            clock,
  input logic            resetn,
  input logic            read,
  input logic            write,
  input logic            ready,
  input logic            error,
  input rw_pkg::state_t  r_state
);

  logic [rw_pkg::MAX_WAIT:0] r_wr_pipe;
  logic                      r_rdy_q;
  logic                      r_coll_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_pipe <= '0;
      r_rdy_q   <= 1'b0;
      r_coll_q  <= 1'b0;
    end else begin
      r_wr_pipe <= {r_wr_pipe[rw_pkg::MAX_WAIT-1:0],
                    write && !read && (r_state == rw_pkg::IDLE)};
      r_rdy_q   <= ready;
      r_coll_q  <= read && write;

      // A collision is legal stimulus but must always be flagged.
      a_excl: assert (!r_coll_q || error || ready)
        else $error("a_excl: read&&write not flagged");
      a_rdy_pulse: assert (!(r_rdy_q && ready))
        else $error("a_rdy_pulse: ready high on consecutive cycles");
      a_lat: assert (!r_wr_pipe[WAIT] || ready)
        else $error("a_lat: ready missing WAIT+1 cycles after write");
      a_rdy_state: assert (!ready || (r_state == rw_pkg::RESP))
        else $error("a_rdy_state: ready outside RESP");
      a_err_rdy: assert (!(error && ready))
        else $error("a_err_rdy: error and ready together");
    end
  end

endmodule

bind rw_responder rw_responder_properties #(.WAIT(WAIT)) u_props (.*);

// File: rtl/rw_responder.sv
// Target side of the read/write/ready handshake: accepts a request in IDLE, waits WAIT
// cycles, then commits the access and pulses ready with read data on the same cycle.
module rw_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WAIT   = 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              error
);

  import rw_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_next_cnt;
  op_t               r_op;
  op_t               w_acc_op;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              r_err_pend;
  logic              w_accept;
  logic              w_err_evt;
  logic              w_commit;
  logic              w_commit_wr;
  logic              w_load_rd;
  logic              w_next_error;
  logic              w_next_err_pend;

  // Next-state, access selection and output decode.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_accept     = 1'b0;
    w_err_evt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (read && write) begin
          w_err_evt = 1'b1;
        end else if (read || write) begin
          w_accept = 1'b1;
          if (WAIT == 0) begin
            w_next_state = RESP;
          end else begin
            w_next_state = rw_pkg::WAIT;
            w_next_cnt   = CNT_W'(WAIT - 1);
          end
        end
      end
      rw_pkg::WAIT: begin
        w_err_evt = read || write;
        if (r_cnt == '0) begin
          w_next_state = RESP;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        w_err_evt    = read || write;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase

    // With zero wait states the access commits on the acceptance edge, so use the live request.
    w_acc_op    = (r_state == IDLE) ? (write ? OP_WRITE : OP_READ) : r_op;
    w_acc_addr  = (r_state == IDLE) ? addr  : r_addr;
    w_acc_wdata = (r_state == IDLE) ? wdata : r_wdata;

    w_commit    = (w_next_state == RESP);
    w_commit_wr = w_commit && (w_acc_op == OP_WRITE);
    w_load_rd   = w_commit && (w_acc_op == OP_READ);

    // An error that would land on the ready cycle is deferred one cycle so the two never overlap.
    w_next_error    = (w_err_evt || r_err_pend) && !w_commit;
    w_next_err_pend = (w_err_evt || r_err_pend) && w_commit;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_op       <= OP_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err_pend <= 1'b0;
      ready      <= 1'b0;
      error      <= 1'b0;
      rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= w_acc_op;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      r_err_pend <= w_next_err_pend;
      ready      <= w_commit;
      error      <= w_next_error;
      if (w_load_rd) begin
        rdata <= w_mem_rdata;
      end
    end
  end

  rw_regfile #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regfile (
    .clock    (clock),
    .resetn   (resetn),
    .i_we     (w_commit_wr),
    .i_waddr  (w_acc_addr),
    .i_wdata  (w_acc_wdata),
    .i_raddr  (w_acc_addr),
    .o_rdata_c(w_mem_rdata)
  );

endmodule

// File: tb/tb_rw_responder.sv
// Directed bench for rw_responder: three instances at WAIT=0, 1 and 3 share one clock.
module tb_rw_responder;

  logic            clk = 1'b0;
  logic [2:0]      rst_n;
  logic [2:0]      rd;
  logic [2:0]      wr;
  logic [2:0][3:0] ad;
  logic [2:0][7:0] wd;
  wire  [2:0]      rdy;
  wire  [2:0]      err;
  wire  [2:0][7:0] rdt;

  int total;
  int bad;

  always #5 clk = ~clk;

  rw_responder #(.ADDR_W(4), .DATA_W(8), .WAIT(0)) u_w0 (
    .clock(clk), .resetn(rst_n[0]), .read(rd[0]), .write(wr[0]), .addr(ad[0]),
    .wdata(wd[0]), .ready(rdy[0]), .rdata(rdt[0]), .error(err[0])
  );

  rw_responder #(.ADDR_W(4), .DATA_W(8), .WAIT(1)) u_w1 (
    .clock(clk), .resetn(rst_n[1]), .read(rd[1]), .write(wr[1]), .addr(ad[1]),
    .wdata(wd[1]), .ready(rdy[1]), .rdata(rdt[1]), .error(err[1])
  );

  rw_responder #(.ADDR_W(4), .DATA_W(8), .WAIT(3)) u_w3 (
    .clock(clk), .resetn(rst_n[2]), .read(rd[2]), .write(wr[2]), .addr(ad[2]),
    .wdata(wd[2]), .ready(rdy[2]), .rdata(rdt[2]), .error(err[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++; if (rdy !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b want=000", rdy); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_error got=%b want=000", err); end
    total++; if (rdt !== 24'h0) begin bad++; $display("FAIL reset_rdata got=%h want=000000", rdt); end
    rst_n = 3'b111;
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if (rdy !== 3'b000) begin bad++; $display("FAIL idle_ready c=%0d got=%b want=000", c, rdy); end
      total++; if (err !== 3'b000) begin bad++; $display("FAIL idle_error c=%0d got=%b want=000", c, err); end
      total++; if (rdt !== 24'h0) begin bad++; $display("FAIL idle_rdata c=%0d got=%h want=000000", c, rdt); end
    end
  endtask

  task automatic test_write_read();
    step();
    wr[1] = 1'b1; ad[1] = 4'd3; wd[1] = 8'hA5;
    step(); wr[1] = 1'b0;
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL wr_t1_ready got=%b want=0", rdy[1]); end
    step();
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL wr_t2_ready got=%b want=1", rdy[1]); end
    total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL wr_t2_error got=%b want=0", err[1]); end
    total++; if (rdt[1] !== 8'h00) begin bad++; $display("FAIL wr_keeps_rdata got=%h want=00", rdt[1]); end
    step();
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL wr_t3_ready got=%b want=0", rdy[1]); end
    rd[1] = 1'b1; ad[1] = 4'd3;
    step(); rd[1] = 1'b0;
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL rd_t4_ready got=%b want=0", rdy[1]); end
    step();
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL rd_t5_ready got=%b want=1", rdy[1]); end
    total++; if (rdt[1] !== 8'hA5) begin bad++; $display("FAIL rd_t5_rdata got=%h want=a5", rdt[1]); end
    step();
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL rd_t6_ready got=%b want=0", rdy[1]); end
    total++; if (rdt[1] !== 8'hA5) begin bad++; $display("FAIL rd_t6_hold got=%h want=a5", rdt[1]); end
  endtask

  task automatic test_zero_wait();
    step();
    rd[0] = 1'b1; ad[0] = 4'd0;
    step(); rd[0] = 1'b0;
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL zw_t1_ready got=%b want=1", rdy[0]); end
    total++; if (rdt[0] !== 8'h00) begin bad++; $display("FAIL zw_t1_rdata got=%h want=00", rdt[0]); end
    step();
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL zw_t2_ready got=%b want=0", rdy[0]); end
  endtask

  task automatic test_back_to_back();
    step();
    wr[0] = 1'b1; ad[0] = 4'd7; wd[0] = 8'hC3;
    step(); wr[0] = 1'b0;
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_wr_ready got=%b want=1", rdy[0]); end
    total++; if (rdt[0] !== 8'h00) begin bad++; $display("FAIL b2b_wr_rdata got=%h want=00", rdt[0]); end
    step();
    total++; if (rdy[0] !== 1'b0) begin bad++; $display("FAIL b2b_gap_ready got=%b want=0", rdy[0]); end
    rd[0] = 1'b1; ad[0] = 4'd7;
    step(); rd[0] = 1'b0;
    total++; if (rdy[0] !== 1'b1) begin bad++; $display("FAIL b2b_rd_ready got=%b want=1", rdy[0]); end
    total++; if (rdt[0] !== 8'hC3) begin bad++; $display("FAIL b2b_rd_rdata got=%h want=c3", rdt[0]); end
    total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL b2b_rd_error got=%b want=0", err[0]); end
  endtask

  task automatic test_collision();
    step();
    rd[1] = 1'b1; wr[1] = 1'b1; ad[1] = 4'd5; wd[1] = 8'h3C;
    step(); rd[1] = 1'b0; wr[1] = 1'b0;
    total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL coll_t1_error got=%b want=1", err[1]); end
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL coll_t1_ready got=%b want=0", rdy[1]); end
    step();
    total++; if (err[1] !== 1'b0) begin bad++; $display("FAIL coll_t2_error got=%b want=0", err[1]); end
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL coll_t2_ready got=%b want=0", rdy[1]); end
    rd[1] = 1'b1; ad[1] = 4'd5;
    step(); rd[1] = 1'b0;
    step();
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL coll_rd_ready got=%b want=1", rdy[1]); end
    total++; if (rdt[1] !== 8'h00) begin bad++; $display("FAIL coll_rd_rdata got=%h want=00", rdt[1]); end
  endtask

  task automatic test_busy_drop();
    int n;
    step();
    wr[2] = 1'b1; ad[2] = 4'd1; wd[2] = 8'h11;
    step(); wr[2] = 1'b0; rd[2] = 1'b1; ad[2] = 4'd1;
    total++; if (err[2] !== 1'b0) begin bad++; $display("FAIL busy_t1_error got=%b want=0", err[2]); end
    step(); rd[2] = 1'b0;
    total++; if (err[2] !== 1'b1) begin bad++; $display("FAIL busy_t2_error got=%b want=1", err[2]); end
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL busy_t2_ready got=%b want=0", rdy[2]); end
    step();
    total++; if (err[2] !== 1'b0) begin bad++; $display("FAIL busy_t3_error got=%b want=0", err[2]); end
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL busy_t3_ready got=%b want=0", rdy[2]); end
    step();
    total++; if (rdy[2] !== 1'b1) begin bad++; $display("FAIL busy_t4_ready got=%b want=1", rdy[2]); end
    total++; if (rdt[2] !== 8'h00) begin bad++; $display("FAIL busy_t4_rdata got=%h want=00", rdt[2]); end
    step();
    total++; if (rdy[2] !== 1'b0) begin bad++; $display("FAIL busy_t5_ready got=%b want=0", rdy[2]); end
    rd[2] = 1'b1; ad[2] = 4'd1;
    n = 0;
    for (int c = 6; c <= 8; c++) begin
      step();
      rd[2] = 1'b0;
      n += int'(rdy[2]);
    end
    total++; if (n != 0) begin bad++; $display("FAIL busy_early_ready got=%0d want=0", n); end
    step();
    total++; if (rdy[2] !== 1'b1) begin bad++; $display("FAIL busy_rd_ready got=%b want=1", rdy[2]); end
    total++; if (rdt[2] !== 8'h11) begin bad++; $display("FAIL busy_rd_rdata got=%h want=11", rdt[2]); end
  endtask

  task automatic test_busy_resp();
    step();
    wr[1] = 1'b1; ad[1] = 4'd9; wd[1] = 8'h77;
    step(); wr[1] = 1'b0;
    step();
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL resp_t2_ready got=%b want=1", rdy[1]); end
    rd[1] = 1'b1; ad[1] = 4'd9;
    step(); rd[1] = 1'b0;
    total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL resp_t3_error got=%b want=1", err[1]); end
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL resp_t3_ready got=%b want=0", rdy[1]); end
    step();
    total++; if ({rdy[1], err[1]} !== 2'b00) begin bad++; $display("FAIL resp_t4_quiet got=%b want=00", {rdy[1], err[1]}); end
    step();
    total++; if (rdy[1] !== 1'b0) begin bad++; $display("FAIL resp_t5_ready got=%b want=0", rdy[1]); end
    rd[1] = 1'b1; ad[1] = 4'd9;
    step(); rd[1] = 1'b0;
    step();
    total++; if (rdy[1] !== 1'b1) begin bad++; $display("FAIL resp_rd_ready got=%b want=1", rdy[1]); end
    total++; if (rdt[1] !== 8'h77) begin bad++; $display("FAIL resp_rd_rdata got=%h want=77", rdt[1]); end
  endtask

  task automatic test_reset_mid();
    int n;
    step();
    wr[2] = 1'b1; ad[2] = 4'd2; wd[2] = 8'hFF;
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) wr[2] = 1'b0;
      if (c == 2) rst_n[2] = 1'b0;
      if (c == 4) rst_n[2] = 1'b1;
      n += int'(rdy[2]);
    end
    total++; if (n != 0) begin bad++; $display("FAIL rmid_ready_count got=%0d want=0", n); end
    total++; if (rdt[2] !== 8'h00) begin bad++; $display("FAIL rmid_rdata_cleared got=%h want=00", rdt[2]); end
    rd[2] = 1'b1; ad[2] = 4'd2;
    n = 0;
    for (int c = 9; c <= 11; c++) begin
      step();
      rd[2] = 1'b0;
      n += int'(rdy[2]);
    end
    total++; if (n != 0) begin bad++; $display("FAIL rmid_early_ready got=%0d want=0", n); end
    step();
    total++; if (rdy[2] !== 1'b1) begin bad++; $display("FAIL rmid_rd_ready got=%b want=1", rdy[2]); end
    total++; if (rdt[2] !== 8'h00) begin bad++; $display("FAIL rmid_rd_rdata got=%h want=00", rdt[2]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 3'b000;
    rd    = '0;
    wr    = '0;
    ad    = '0;
    wd    = '0;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_back_to_back();
    test_collision();
    test_busy_drop();
    test_busy_resp();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
